// File: rtl/dprx_pkg.sv
// Shared types and constants for the data-plane receive path.
//   dprx_state_e : receive FSM states
//   dprx_pkt_t   : data-plane word layout {src_id, payload}
//   NULL_PAYLOAD : payload value that never carries data
package dprx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } dprx_state_e;

    typedef struct packed {
        logic [15:0] src_id;
        logic [15:0] payload;
    } dprx_pkt_t;

    localparam logic [15:0] NULL_PAYLOAD = 16'h0000;

endpackage

// File: rtl/rx_stack_ram.sv
// Stack storage for received payloads: one write port, one registered read port.
// Ports:
//   clk, rst : clock, synchronous active-high reset (clears the read register only)
//   we, waddr, wdata : write port
//   re, raddr        : read request; rdata updates on the next edge, holds otherwise
//   rdata            : registered read data
module rx_stack_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned AW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage array, never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_plane_rx.sv
// Data-plane receiver: filters granted-source packets into a LIFO stack and
// lets the GPP pop them one word per cycle.
// Optional feature: define DPRX_TIMEOUT_EN to abort a reception after
// TIMEOUT_CYCLES consecutive cycles without an accepted packet.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   data_rx_flag           : reception granted by the control plane
//   data_rx_node_id        : granted source node
//   data_rx_packet         : {src_id, payload}
//   gpp_rtr                : pop request
//   data_rx_complete_flag  : high while the transfer is finished (DONE)
//   rtr_data, rtr_valid    : popped word, valid for one cycle per pop
//   sp_rx_current          : number of stored words
//   rx_full                : stack full
//   rx_overflow            : sticky, a word was dropped on full
//   rx_timeout             : sticky, a transfer was aborted by timeout
module data_plane_rx
    import dprx_pkg::*;
#(
    parameter int unsigned RAM_DEPTH      = 64,
    parameter int unsigned PKT_PER_XFER   = 5,
    parameter int unsigned TIMEOUT_CYCLES = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_rx_flag,
    input  logic [15:0] data_rx_node_id,
    input  logic [31:0] data_rx_packet,
    input  logic        gpp_rtr,
    output logic        data_rx_complete_flag,
    output logic [15:0] rtr_data,
    output logic        rtr_valid,
    output logic [15:0] sp_rx_current,
    output logic        rx_full,
    output logic        rx_overflow,
    output logic        rx_timeout
);

    localparam int unsigned AW  = $clog2(RAM_DEPTH);
    localparam int unsigned SPW = AW + 1;
    localparam int unsigned PCW = $clog2(PKT_PER_XFER + 1);

    localparam logic [SPW-1:0] SP_FULL  = SPW'(RAM_DEPTH);
    localparam logic [PCW-1:0] PKT_LAST = PCW'(PKT_PER_XFER);

    // Parameter legality.
    if ((RAM_DEPTH < 2) || ((RAM_DEPTH & (RAM_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("RAM_DEPTH must be a power of two and at least 2");
    end
    if (PKT_PER_XFER == 0) begin : g_bad_pkt
        $error("PKT_PER_XFER must be nonzero");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    dprx_state_e    state_q, state_d;
    logic [PCW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           ovf_q, ovf_d;
    logic           complete_q;
    logic           full_q;
    logic           rtr_valid_q;

    logic           accept_c;
    logic           push_c;
    logic           pop_c;
    dprx_pkt_t      pkt_c;

`ifdef DPRX_TIMEOUT_EN
    localparam int unsigned ICW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ICW-1:0] IDLE_LAST = ICW'(TIMEOUT_CYCLES);

    logic [ICW-1:0] idle_cnt_q, idle_cnt_d;
    logic           tmo_q, tmo_d;
`endif

    assign pkt_c = dprx_pkt_t'(data_rx_packet);

    // Next-state, stack pointer and sticky-flag logic.
    always_comb begin
        state_d   = state_q;
        pkt_cnt_d = pkt_cnt_q;
        sp_d      = sp_q;
        ovf_d     = ovf_q;
        accept_c  = 1'b0;
        push_c    = 1'b0;
        pop_c     = 1'b0;
`ifdef DPRX_TIMEOUT_EN
        idle_cnt_d = idle_cnt_q;
        tmo_d      = tmo_q;
`endif

        if ((state_q == RECV) && (pkt_c.src_id == data_rx_node_id) &&
            (pkt_c.payload != NULL_PAYLOAD)) begin
            accept_c = 1'b1;
        end

        // A push always wins over a pop in the same cycle.
        push_c = accept_c && (sp_q != SP_FULL);
        pop_c  = gpp_rtr && (sp_q != '0) && !push_c;

        if (push_c) begin
            sp_d = sp_q + SPW'(1);
        end else if (pop_c) begin
            sp_d = sp_q - SPW'(1);
        end

        if (accept_c && (sp_q == SP_FULL)) begin
            ovf_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (data_rx_flag) begin
                    state_d   = RECV;
                    pkt_cnt_d = '0;
`ifdef DPRX_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                end
            end
            RECV: begin
                // Dropped packets still count toward the transfer.
                if (accept_c) begin
                    pkt_cnt_d = pkt_cnt_q + PCW'(1);
                end
`ifdef DPRX_TIMEOUT_EN
                if (accept_c) begin
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + ICW'(1);
                end
`endif
                if (!data_rx_flag) begin
                    state_d = IDLE;
                end else if (accept_c && ((pkt_cnt_q + PCW'(1)) == PKT_LAST)) begin
                    state_d = DONE;
                end
`ifdef DPRX_TIMEOUT_EN
                else if (!accept_c && ((idle_cnt_q + ICW'(1)) == IDLE_LAST)) begin
                    state_d = DONE;
                    tmo_d   = 1'b1;
                end
`endif
            end
            DONE: begin
                if (!data_rx_flag) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pkt_cnt_q   <= '0;
            sp_q        <= '0;
            ovf_q       <= 1'b0;
            complete_q  <= 1'b0;
            full_q      <= 1'b0;
            rtr_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pkt_cnt_q   <= pkt_cnt_d;
            sp_q        <= sp_d;
            ovf_q       <= ovf_d;
            complete_q  <= (state_d == DONE);
            full_q      <= (sp_d == SP_FULL);
            rtr_valid_q <= pop_c;
        end
    end

`ifdef DPRX_TIMEOUT_EN
    // Idle counter and timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_q <= '0;
            tmo_q      <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            tmo_q      <= tmo_d;
        end
    end

    assign rx_timeout = tmo_q;
`else
    assign rx_timeout = 1'b0;
`endif

    rx_stack_ram #(
        .DEPTH (RAM_DEPTH),
        .WIDTH (16),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (push_c),
        .waddr (AW'(sp_q)),
        .wdata (pkt_c.payload),
        .re    (pop_c),
        .raddr (AW'(sp_q - SPW'(1))),
        .rdata (rtr_data)
    );

    assign data_rx_complete_flag = complete_q;
    assign rtr_valid             = rtr_valid_q;
    assign sp_rx_current         = 16'(sp_q);
    assign rx_full               = full_q;
    assign rx_overflow           = ovf_q;

endmodule

// File: tb/tb_data_plane_rx.sv
// Directed bench for data_plane_rx: a default-depth instance and a depth-4
// instance share one stimulus stream.
module tb_data_plane_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_rx_flag;
    logic [15:0] data_rx_node_id;
    logic [31:0] data_rx_packet;
    logic        gpp_rtr;

    logic        comp_a, valid_a, full_a, ovf_a, tmo_a;
    logic [15:0] data_a, sp_a;
    logic        comp_b, valid_b, full_b, ovf_b, tmo_b;
    logic [15:0] data_b, sp_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_plane_rx dut (
        .clk                   (clk),
        .rst                   (rst),
        .data_rx_flag          (data_rx_flag),
        .data_rx_node_id       (data_rx_node_id),
        .data_rx_packet        (data_rx_packet),
        .gpp_rtr               (gpp_rtr),
        .data_rx_complete_flag (comp_a),
        .rtr_data              (data_a),
        .rtr_valid             (valid_a),
        .sp_rx_current         (sp_a),
        .rx_full               (full_a),
        .rx_overflow           (ovf_a),
        .rx_timeout            (tmo_a)
    );

    data_plane_rx #(.RAM_DEPTH(4)) dut4 (
        .clk                   (clk),
        .rst                   (rst),
        .data_rx_flag          (data_rx_flag),
        .data_rx_node_id       (data_rx_node_id),
        .data_rx_packet        (data_rx_packet),
        .gpp_rtr               (gpp_rtr),
        .data_rx_complete_flag (comp_b),
        .rtr_data              (data_b),
        .rtr_valid             (valid_b),
        .sp_rx_current         (sp_b),
        .rx_full               (full_b),
        .rx_overflow           (ovf_b),
        .rx_timeout            (tmo_b)
    );

    typedef struct {
        logic        flag;
        logic [31:0] pkt;
        logic        rtr;
        logic        comp;
        logic        valid;
        logic [15:0] data;
        logic [15:0] sp;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic f, input logic [31:0] p, input logic r);
        data_rx_flag   = f;
        data_rx_packet = p;
        gpp_rtr        = r;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic send_n(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b1, base + 32'(k), 1'b0);
            step();
        end
    endtask

    initial begin
        // flag, pkt, rtr | complete, valid, data, sp
        vecs[0]  = '{1'b1, 32'h0003_00A1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0}; // IDLE ignores
        vecs[1]  = '{1'b1, 32'h0003_00A1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd1};
        vecs[2]  = '{1'b1, 32'h0007_1234, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd1}; // wrong node
        vecs[3]  = '{1'b1, 32'h0003_0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd1}; // null payload
        vecs[4]  = '{1'b1, 32'h0003_00A2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd2};
        vecs[5]  = '{1'b1, 32'h0003_00A3, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd3};
        vecs[6]  = '{1'b1, 32'h0003_00A4, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd4};
        vecs[7]  = '{1'b1, 32'h0003_00A5, 1'b1, 1'b1, 1'b0, 16'h0000, 16'd5}; // push beats pop
        vecs[8]  = '{1'b1, 32'h0003_00B0, 1'b1, 1'b1, 1'b1, 16'h00A5, 16'd4}; // DONE ignores pkt
        vecs[9]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 16'h00A4, 16'd3};
        vecs[10] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 16'h00A3, 16'd2};
        vecs[11] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 16'h00A2, 16'd1};
        vecs[12] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 16'h00A1, 16'd0};
        vecs[13] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'd0}; // pop on empty
        vecs[14] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0};

        data_rx_node_id = 16'd3;
        drive(1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        chk("rst_complete", 32'(comp_a), 32'd0);
        chk("rst_valid",    32'(valid_a), 32'd0);
        chk("rst_data",     32'(data_a), 32'd0);
        chk("rst_sp",       32'(sp_a), 32'd0);
        chk("rst_full",     32'(full_a), 32'd0);
        chk("rst_ovf",      32'(ovf_a), 32'd0);
        chk("rst_tmo",      32'(tmo_a), 32'd0);
        chk("rst_sp4",      32'(sp_b), 32'd0);

        // Main transfer, filtering and LIFO pops.
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].flag, vecs[i].pkt, vecs[i].rtr);
            step();
            chk($sformatf("vec%0d_complete", i), 32'(comp_a), 32'(vecs[i].comp));
            chk($sformatf("vec%0d_valid", i), 32'(valid_a), 32'(vecs[i].valid));
            chk($sformatf("vec%0d_sp", i), 32'(sp_a), 32'(vecs[i].sp));
            if (vecs[i].valid) begin
                chk($sformatf("vec%0d_data", i), 32'(data_a), 32'(vecs[i].data));
            end
        end
        chk("main_ovf", 32'(ovf_a), 32'd0);

        // Overflow on the depth-4 instance.
        do_reset();
        drive(1'b1, 32'h0, 1'b0);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h0003_00A1 + 32'(k), 1'b0);
            step();
            if (k == 3) begin
                chk("ovf_full_at4", 32'(full_b), 32'd1);
                chk("ovf_ovf_at4",  32'(ovf_b), 32'd0);
            end
        end
        chk("ovf_sp4",       32'(sp_b), 32'd4);
        chk("ovf_full4",     32'(full_b), 32'd1);
        chk("ovf_flag4",     32'(ovf_b), 32'd1);
        chk("ovf_complete4", 32'(comp_b), 32'd1);
        chk("ovf_sp64",      32'(sp_a), 32'd5);
        chk("ovf_flag64",    32'(ovf_a), 32'd0);
        drive(1'b0, 32'h0, 1'b1);
        step();
        chk("ovf_pop_valid", 32'(valid_b), 32'd1);
        chk("ovf_pop_data",  32'(data_b), 32'h00A4);
        chk("ovf_pop_full",  32'(full_b), 32'd0);

        // Reset in the middle of a transfer.
        do_reset();
        drive(1'b1, 32'h0, 1'b0);
        step();
        send_n(32'h0003_00A1, 2);
        chk("mid_sp_before", 32'(sp_a), 32'd2);
        rst = 1'b1;
        drive(1'b1, 32'h0003_00A3, 1'b0);
        step();
        rst = 1'b0;
        chk("mid_sp",       32'(sp_a), 32'd0);
        chk("mid_complete", 32'(comp_a), 32'd0);
        chk("mid_valid",    32'(valid_a), 32'd0);
        drive(1'b1, 32'h0003_00C1, 1'b0);
        step();
        chk("mid_idle_ignores", 32'(sp_a), 32'd0);
        send_n(32'h0003_00C1, 4);
        chk("mid_not_done_at4", 32'(comp_a), 32'd0);
        send_n(32'h0003_00C5, 1);
        chk("mid_done_at5", 32'(comp_a), 32'd1);
        chk("mid_sp5",      32'(sp_a), 32'd5);

        // Grant withdrawn during reception.
        do_reset();
        drive(1'b1, 32'h0, 1'b0);
        step();
        send_n(32'h0003_00D1, 2);
        drive(1'b0, 32'h0, 1'b0);
        step();
        chk("drop_complete", 32'(comp_a), 32'd0);
        chk("drop_sp_kept",  32'(sp_a), 32'd2);
        drive(1'b0, 32'h0003_00D3, 1'b0);
        step();
        chk("drop_idle_ignores", 32'(sp_a), 32'd2);
        drive(1'b1, 32'h0, 1'b0);
        step();
        send_n(32'h0003_00E1, 3);
        chk("drop_cnt_cleared", 32'(comp_a), 32'd0);
        send_n(32'h0003_00E4, 2);
        chk("drop_done",   32'(comp_a), 32'd1);
        chk("drop_sp7",    32'(sp_a), 32'd7);

        // Idle timeout.
        do_reset();
        drive(1'b1, 32'h0, 1'b0);
        step();
        send_n(32'h0003_00F1, 2);
        drive(1'b1, 32'h0, 1'b0);
        for (int c = 0; c < 47; c++) begin
            step();
        end
        chk("tmo_before_complete", 32'(comp_a), 32'd0);
        chk("tmo_before_flag",     32'(tmo_a), 32'd0);
        step();
`ifdef DPRX_TIMEOUT_EN
        chk("tmo_complete", 32'(comp_a), 32'd1);
        chk("tmo_flag",     32'(tmo_a), 32'd1);
        chk("tmo_sp",       32'(sp_a), 32'd2);
`else
        chk("tmo_off_complete", 32'(comp_a), 32'd0);
        chk("tmo_off_flag",     32'(tmo_a), 32'd0);
        for (int c = 0; c < 12; c++) begin
            step();
        end
        send_n(32'h0003_00F3, 3);
        chk("tmo_off_still_recv", 32'(comp_a), 32'd1);
        chk("tmo_off_sp",         32'(sp_a), 32'd5);
        chk("tmo_off_flag_end",   32'(tmo_a), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_plane_rx.md
DATA_PLANE_RX -- requirements
Module: data_plane_rx

Interface
REQ-001 SHALL have parameter RAM_DEPTH, default 64: rx RAM depth in 16-bit words, power of two.
REQ-002 SHALL have parameter PKT_PER_XFER, default 5: data packets per granted transfer.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 48: idle-cycle abort limit during reception.
REQ-004 SHALL have port clk, in, 1: clock.
REQ-005 SHALL have port rst, in, 1: reset, synchronous, active-high.
REQ-006 SHALL have port data_rx_flag, in, 1: control plane has granted a reception.
REQ-007 SHALL have port data_rx_node_id, in, 16: granted source node (wavelength filter).
REQ-008 SHALL have port data_rx_packet, in, 32: data plane word, {src_id[31:16], payload[15:0]}.
REQ-009 SHALL have port gpp_rtr, in, 1: GPP pop request, one word per cycle.
REQ-010 SHALL have port data_rx_complete_flag, out, 1: transfer finished; the control plane clears data_rx_flag on it.
REQ-011 SHALL have port rtr_data, out, 16: popped word.
REQ-012 SHALL have port rtr_valid, out, 1: rtr_data valid.
REQ-013 SHALL have port sp_rx_current, out, 16: stack pointer, equal to the number of stored words.
REQ-014 SHALL have port rx_full, out, 1: sp_rx_current == RAM_DEPTH.
REQ-015 SHALL have port rx_overflow, out, 1: sticky flag, a word was dropped on full.
REQ-016 SHALL have port rx_timeout, out, 1: sticky flag, a transfer was aborted by timeout.

Function
REQ-017 SHALL implement FSM states IDLE, RECV, DONE.
- IDLE -> RECV when data_rx_flag=1.
- Entering RECV clears pkt_cnt and idle_cnt.
REQ-018 In RECV, a packet SHALL be accepted iff data_rx_packet[31:16]==data_rx_node_id and data_rx_packet[15:0]!=0x0000.
REQ-019 An accepted packet SHALL be pushed: mem[sp]<=payload, sp<=sp+1, write visible to a pop on the next cycle.
REQ-020 An accepted packet while rx_full=1 SHALL be dropped, set rx_overflow, and still increment pkt_cnt.
REQ-021 On the accept that makes pkt_cnt reach PKT_PER_XFER, the FSM SHALL go RECV -> DONE.
REQ-022 In DONE, data_rx_complete_flag SHALL be 1 (registered, first high the cycle after the final accept); DONE -> IDLE when data_rx_flag=0.
REQ-023 data_rx_flag falling while in RECV SHALL return the FSM to IDLE without asserting complete; stored words are kept.
REQ-024 Pop: gpp_rtr=1 and sp>0 and no push in the same cycle SHALL give rtr_data<=mem[sp-1], sp<=sp-1, rtr_valid=1 on the next cycle only.
REQ-025 A pop SHALL be ignored (rtr_valid=0 next cycle, sp unchanged) when sp==0 or a push occurs in the same cycle; the push takes priority.
REQ-026 sp SHALL never wrap: no push above RAM_DEPTH, no pop below 0.
REQ-027 Packets arriving in IDLE or DONE SHALL be ignored.

Reset
REQ-028 rst SHALL force the FSM to IDLE and clear sp_rx_current, pkt_cnt, idle_cnt, data_rx_complete_flag, rtr_valid, rtr_data, rx_overflow and rx_timeout, taking effect at the next clk edge including mid-transfer; RAM contents are not cleared.

Configuration
REQ-029 With DPRX_TIMEOUT_EN defined:
- idle_cnt increments each RECV cycle without an accept and clears on accept.
- When idle_cnt reaches TIMEOUT_CYCLES, the FSM SHALL go RECV -> DONE and set rx_timeout.
REQ-030 Without DPRX_TIMEOUT_EN, no idle counter SHALL exist, rx_timeout SHALL be tied to 0, and RECV is left only per REQ-021/REQ-023.

Structure
REQ-031 A shared package dprx_pkg SHALL hold the FSM state enum, the packet-field typedef {src_id, payload}, and constant NULL_PAYLOAD=16'h0000.
REQ-032 Stack storage SHALL be a sub-module rx_stack_ram (single write port, single registered read port); FSM and filter SHALL stay in data_plane_rx.

Verification
REQ-033 Scenario: data_rx_node_id=3, data_rx_flag=1, five packets 0x0003_00A1..0x0003_00A5 -> sp=5, complete high the cycle after the fifth, five pops return A5,A4,A3,A2,A1.
REQ-034 Scenario: interleave packet 0x0007_1234 while granted node=3 -> not stored, pkt_cnt unchanged, sp unchanged.
REQ-035 Scenario: RAM_DEPTH=4, five valid packets -> sp=4, rx_full=1, rx_overflow=1, complete still asserted.
REQ-036 Scenario: gpp_rtr held with a push in the same cycle -> no pop that cycle, rtr_valid=0; the pop succeeds on the following cycle; pop at sp=0 -> rtr_valid=0.
REQ-037 Scenario: rst asserted after 2 of 5 packets -> next cycle IDLE, sp=0, complete=0.
REQ-038 Scenario (DPRX_TIMEOUT_EN): 2 packets then 48 idle cycles -> DONE, rx_timeout=1, complete=1; without the macro -> stays in RECV.
